// File: rtl/osd_scm_rstctl.sv
// Subnet control module reset controller: ID registers plus per-channel level and pulse resets.
// Define OSD_SCM_RST_STATUS_EN to add the sticky pulse-completion register at 0x208.
module osd_scm_rstctl_ch (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [15:0] load_len,
  output logic        active,
  output logic        last
);
  logic [15:0] cnt;

  // A trigger always reloads, so retriggering restarts rather than accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (trig)
      cnt <= load_len;
    else if (cnt != 16'd0)
      cnt <= cnt - 16'd1;
  end

  assign active = (cnt != 16'd0);
  assign last   = (cnt == 16'd1) && !trig;
endmodule

module osd_scm_rstctl #(
  parameter logic [15:0] SYSTEM_VENDOR_ID  = 16'd0,
  parameter logic [15:0] SYSTEM_DEVICE_ID  = 16'd0,
  parameter logic [15:0] NUM_MOD           = 16'd1,
  parameter logic [15:0] MAX_PKT_LEN       = 16'd8,
  parameter int          NUM_RST_CH        = 2,
  parameter logic [15:0] PULSE_LEN_DEFAULT = 16'd16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_request,
  input  logic                  reg_write,
  input  logic [15:0]           reg_addr,
  input  logic [1:0]            reg_size,
  input  logic [15:0]           reg_wdata,
  output logic                  reg_ack,
  output logic                  reg_err,
  output logic [15:0]           reg_rdata,
  output logic [NUM_RST_CH-1:0] rst_out
);
  localparam int CW = NUM_RST_CH;

  logic [CW-1:0] rst_level;
  logic [15:0]   pulse_len;
  logic [15:0]   pulse_load;
  logic [CW-1:0] trig;
  logic [CW-1:0] active;
  logic [CW-1:0] last;
  logic [CW-1:0] status;

  logic hit_id, hit_level, hit_pulse, hit_len, hit_nch, hit_stat;
  logic mapped, ro, wr_ok, rd_ok;
  logic [15:0] rd_val;

  always_comb begin
    hit_id    = (reg_addr >= 16'h0200) && (reg_addr <= 16'h0203);
    hit_level = (reg_addr == 16'h0204);
    hit_pulse = (reg_addr == 16'h0205);
    hit_len   = (reg_addr == 16'h0206);
    hit_nch   = (reg_addr == 16'h0207);
`ifdef OSD_SCM_RST_STATUS_EN
    hit_stat  = (reg_addr == 16'h0208);
`else
    hit_stat  = 1'b0;
`endif
    mapped = hit_id | hit_level | hit_pulse | hit_len | hit_nch | hit_stat;
    ro     = hit_id | hit_nch;
  end

  assign wr_ok   = reg_request && reg_write && mapped && !ro;
  assign rd_ok   = reg_request && !reg_write && mapped;
  assign reg_ack = 1'b1;
  assign reg_err = reg_request && (!mapped || (reg_write && ro));

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      16'h0200: rd_val = SYSTEM_VENDOR_ID;
      16'h0201: rd_val = SYSTEM_DEVICE_ID;
      16'h0202: rd_val = NUM_MOD;
      16'h0203: rd_val = MAX_PKT_LEN;
      16'h0204: rd_val[CW-1:0] = rst_level;
      16'h0205: rd_val[CW-1:0] = active;
      16'h0206: rd_val = pulse_len;
      16'h0207: rd_val = 16'(NUM_RST_CH);
      16'h0208: rd_val[CW-1:0] = status;
      default:  rd_val = '0;
    endcase
  end

  assign reg_rdata = rd_ok ? rd_val : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_level <= '0;
      pulse_len <= PULSE_LEN_DEFAULT;
    end else begin
      if (wr_ok && hit_level) rst_level <= reg_wdata[CW-1:0];
      if (wr_ok && hit_len)   pulse_len <= reg_wdata;
    end
  end

  // A zero length still yields a one-cycle pulse.
  assign pulse_load = (pulse_len == 16'd0) ? 16'd1 : pulse_len;
  assign trig       = (wr_ok && hit_pulse) ? reg_wdata[CW-1:0] : '0;

  for (genvar i = 0; i < CW; i++) begin : g_ch
    osd_scm_rstctl_ch u_ch (
      .clk      (clk),
      .rst      (rst),
      .trig     (trig[i]),
      .load_len (pulse_load),
      .active   (active[i]),
      .last     (last[i])
    );
  end

`ifdef OSD_SCM_RST_STATUS_EN
  // Completion set is OR'd in after the clear so it wins a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      status <= '0;
    else if (wr_ok && hit_stat)
      status <= (status & ~reg_wdata[CW-1:0]) | last;
    else
      status <= status | last;
  end
`else
  assign status = '0;
  logic unused_last;
  assign unused_last = ^last;
`endif

  logic unused_size;
  assign unused_size = ^reg_size;

  assign rst_out = rst_level | active | {CW{rst}};
endmodule

// File: tb/tb_osd_scm_rstctl.sv
// Scoreboard bench for osd_scm_rstctl: stimulus pushes expectations, a negedge monitor compares.
module tb_osd_scm_rstctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_request = 1'b0;
  logic        reg_write = 1'b0;
  logic [15:0] reg_addr = '0;
  logic [1:0]  reg_size = '0;
  logic [15:0] reg_wdata = '0;
  logic        reg_ack, reg_err;
  logic [15:0] reg_rdata;
  logic [3:0]  rst_out;

`ifdef OSD_SCM_RST_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  osd_scm_rstctl #(
    .SYSTEM_VENDOR_ID (16'h1234),
    .SYSTEM_DEVICE_ID (16'h5678),
    .NUM_MOD          (16'd3),
    .MAX_PKT_LEN      (16'd8),
    .NUM_RST_CH       (4),
    .PULSE_LEN_DEFAULT(16'd16)
  ) dut (
    .clk(clk), .rst(rst), .reg_request(reg_request), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_size(reg_size), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata), .rst_out(rst_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic [3:0]  rout;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: each channel holds the last cycle its pulse is high (-1 = idle).
  int          pend[4];
  logic [3:0]  m_level;
  logic [3:0]  m_stat;
  logic [15:0] m_len;
  int          cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pend[i] = -1;
    m_level = '0;
    m_stat  = '0;
    m_len   = 16'd16;
  endtask

  task automatic step(input bit r, input bit req, input bit wr,
                      input logic [15:0] a, input logic [15:0] d, input string nm);
    exp_t e;
    logic [3:0] act, done;
    bit mapped, ro;
    int plen;
    @(posedge clk);
    #1;
    rst = r; reg_request = req; reg_write = wr; reg_addr = a; reg_wdata = d;
    reg_size = 2'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) act[i] = (pend[i] >= cyc);
    mapped = (a >= 16'h0200 && a <= 16'h0207) || (STAT_EN && a == 16'h0208);
    ro = (a >= 16'h0200 && a <= 16'h0203) || a == 16'h0207;
    e.ack  = 1'b1;
    e.err  = req && (!mapped || (wr && ro));
    e.rdata = 16'd0;
    if (req && !wr && mapped) begin
      case (a)
        16'h0200: e.rdata = 16'h1234;
        16'h0201: e.rdata = 16'h5678;
        16'h0202: e.rdata = 16'd3;
        16'h0203: e.rdata = 16'd8;
        16'h0204: e.rdata = {12'd0, m_level};
        16'h0205: e.rdata = {12'd0, act};
        16'h0206: e.rdata = m_len;
        16'h0207: e.rdata = 16'd4;
        16'h0208: e.rdata = {12'd0, m_stat};
        default:  e.rdata = 16'd0;
      endcase
    end
    e.rout = r ? 4'hf : (m_level | act);
    e.name = nm;
    exp_q.push_back(e);
    if (r) model_reset();
    else begin
      for (int i = 0; i < 4; i++) done[i] = (pend[i] == cyc);
      if (req && wr && mapped && !ro) begin
        case (a)
          16'h0204: m_level = d[3:0];
          16'h0205: begin
            plen = (m_len == 16'd0) ? 1 : int'(m_len);
            for (int i = 0; i < 4; i++)
              if (d[i]) begin done[i] = 1'b0; pend[i] = cyc + plen; end
          end
          16'h0206: m_len = d;
          16'h0208: m_stat = m_stat & ~d[3:0];
          default: ;
        endcase
      end
      if (STAT_EN) m_stat = m_stat | done;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input string nm);
    for (int k = 0; k < n; k++) step(0, 0, 0, 16'h0, 16'h0, nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (reg_ack !== e.ack || reg_err !== e.err || reg_rdata !== e.rdata || rst_out !== e.rout) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got ack=%b err=%b rdata=%h rst_out=%b, want ack=%b err=%b rdata=%h rst_out=%b",
                 e.name, cyc, reg_ack, reg_err, reg_rdata, rst_out, e.ack, e.err, e.rdata, e.rout);
      end
    end
  end

  initial begin
    logic [15:0] a, d;
    bit wr, req, r;
    model_reset();
    step(1, 0, 0, 16'h0, 16'h0, "reset");
    step(1, 0, 0, 16'h0, 16'h0, "reset");
    idle(1, "post_reset");
    step(0, 1, 0, 16'h0200, 16'h0, "rd_vendor");
    step(0, 1, 0, 16'h0201, 16'h0, "rd_device");
    step(0, 1, 0, 16'h0202, 16'h0, "rd_nummod");
    step(0, 1, 0, 16'h0203, 16'h0, "rd_maxpkt");
    step(0, 1, 0, 16'h0207, 16'h0, "rd_numch");
    step(0, 1, 0, 16'h0206, 16'h0, "rd_len_default");
    step(0, 1, 1, 16'h0204, 16'h0005, "wr_level");
    step(0, 1, 0, 16'h0204, 16'h0, "level_out");
    step(0, 1, 1, 16'h0204, 16'hfff0, "wr_level_hi_ignored");
    step(0, 1, 1, 16'h0203, 16'hffff, "wr_ro_err");
    step(0, 1, 0, 16'h0203, 16'h0, "ro_unchanged");
    step(0, 1, 1, 16'h0206, 16'd3, "len3");
    step(0, 1, 1, 16'h0205, 16'h0002, "trig_ch1");
    idle(1, "pulse_t1");
    step(0, 1, 0, 16'h0205, 16'h0, "busy_t2");
    idle(3, "pulse_tail");
    step(0, 1, 1, 16'h0206, 16'd4, "len4");
    step(0, 1, 1, 16'h0205, 16'h0001, "trig_ch0");
    idle(2, "pulse_mid");
    step(0, 1, 1, 16'h0205, 16'h0001, "retrig_ch0");
    idle(6, "retrig_tail");
    step(0, 1, 1, 16'h0206, 16'd0, "len0");
    step(0, 1, 1, 16'h0205, 16'h0008, "trig_len0");
    idle(2, "len0_tail");
    step(0, 1, 1, 16'h0206, 16'd1, "len1");
    step(0, 1, 1, 16'h0205, 16'h0001, "trig_len1");
    step(0, 1, 1, 16'h0205, 16'h0001, "retrig_at_one");
    idle(2, "retrig_one_tail");
    step(0, 1, 1, 16'h0206, 16'd10, "len10");
    step(0, 1, 1, 16'h0205, 16'h000f, "trig_all");
    idle(1, "pulse_all");
    step(1, 0, 0, 16'h0, 16'h0, "rst_mid_pulse");
    step(1, 0, 0, 16'h0, 16'h0, "rst_mid_pulse");
    idle(2, "post_rst_idle");
    step(0, 1, 0, 16'h0206, 16'h0, "len_after_rst");
    step(0, 1, 1, 16'h0206, 16'd2, "len2");
    step(0, 1, 1, 16'h0205, 16'h0004, "trig_ch2");
    idle(3, "ch2_tail");
    step(0, 1, 0, 16'h0208, 16'h0, "rd_status");
    step(0, 1, 1, 16'h0208, 16'h0004, "w1c_status");
    step(0, 1, 0, 16'h0208, 16'h0, "rd_status_clr");
    step(0, 1, 1, 16'h0200, 16'h0, "wr_vendor_err");
    step(0, 1, 0, 16'h0300, 16'h0, "unmapped_err");
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 11);
      if (sel <= 9) a = 16'h0200 + 16'(sel);
      else if (sel == 10) a = 16'($urandom);
      else a = 16'h0205;
      wr  = 1'($urandom_range(0, 1));
      req = ($urandom_range(0, 9) != 0);
      d   = 16'($urandom);
      if (a == 16'h0206) d = 16'($urandom_range(0, 6));
      if (a == 16'h0204 && $urandom_range(0, 3) != 0) d = 16'h0;
      r = ($urandom_range(0, 59) == 0);
      if (r) step(1, 0, 0, 16'h0, 16'h0, "rand_rst");
      else step(0, req, wr, a, d, "rand");
    end
    idle(1, "drain");
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
